// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder: FSM states,
// read-data source selector and MMIO register map.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESP    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_LED  = 2'd2,
    SRC_CNT  = 2'd3
  } rsrc_t;

  localparam logic [3:0]  MMIO_LED_OFF      = 4'h0;
  localparam logic [3:0]  MMIO_CNT_OFF      = 4'h4;
  localparam int unsigned MMIO_WINDOW_BYTES = 16;

endpackage

// File: rtl/word_ram.sv
// Single-port word RAM with independent write and read enables and a
// registered read port. Contents are intentionally not reset.
module word_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multi-cycle CPU: serves word reads/writes
// from a local RAM or a small MMIO window after a fixed number of wait states.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] MMIO_BASE   = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic [7:0]  leds
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [31:0] MMIO_SIZE = 32'(MMIO_WINDOW_BYTES);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [3:0]  wait_cnt_reg;
  logic [31:0] addr_reg, wdata_reg;
  logic        rd_reg, wr_reg;
  logic        err_lat_reg;
  rsrc_t       src_reg;
  logic [31:0] cnt_sample_reg, cycle_cnt_reg;
  logic [7:0]  leds_reg;
  logic        ready_reg, err_reg;
  logic [31:0] rdata_reg;

  logic        accept, go_resp, in_idle;
  logic [31:0] req_addr, req_wdata, mmio_off;
  logic        req_rd, req_wr;
  logic        in_mmio, is_ram, is_led, is_cnt, req_err;
  rsrc_t       req_src;
  logic        ram_we, ram_re, led_we;
  logic [31:0] ram_q, rdata_mux;

  assign accept  = (state_reg == ST_IDLE) && (mem_read || mem_write);
  assign go_resp = (accept && (WAIT_CYCLES == 0)) ||
                   ((state_reg == ST_WAIT) && (wait_cnt_reg == 4'd0));

  // With zero wait states the access happens on the accept edge itself,
  // so the decode must look at the live request rather than the latches.
  assign in_idle   = (state_reg == ST_IDLE);
  assign req_addr  = in_idle ? addr      : addr_reg;
  assign req_wdata = in_idle ? wdata     : wdata_reg;
  assign req_rd    = in_idle ? mem_read  : rd_reg;
  assign req_wr    = in_idle ? mem_write : wr_reg;

  always_comb begin
    mmio_off = req_addr - MMIO_BASE;
    in_mmio  = (req_addr >= MMIO_BASE) && (mmio_off < MMIO_SIZE);
    is_ram   = !in_mmio && (req_addr < RAM_BYTES);
    is_led   = in_mmio && (mmio_off[3:0] == MMIO_LED_OFF);
    is_cnt   = in_mmio && (mmio_off[3:0] == MMIO_CNT_OFF);
    req_err  = (req_rd && req_wr) || (req_addr[1:0] != 2'b00) ||
               !(is_ram || is_led || is_cnt);
    req_src  = SRC_ZERO;
    if (req_rd && !req_err) begin
      if (is_ram)      req_src = SRC_RAM;
      else if (is_led) req_src = SRC_LED;
      else             req_src = SRC_CNT;
    end
  end

  assign ram_we = go_resp && req_wr && !req_err && is_ram;
  assign ram_re = go_resp && req_rd && !req_err && is_ram;
  assign led_we = go_resp && req_wr && !req_err && is_led;

  word_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (req_addr[AW+1:2]),
    .wdata(req_wdata),
    .rdata(ram_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (go_resp)     state_next = ST_RESP;
        else if (accept) state_next = ST_WAIT;
      end
      ST_WAIT:    if (go_resp) state_next = ST_RESP;
      ST_RESP:    state_next = ST_RELEASE;
      ST_RELEASE: if (!mem_read && !mem_write) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rd_reg         <= 1'b0;
      wr_reg         <= 1'b0;
      wait_cnt_reg   <= '0;
      err_lat_reg    <= 1'b0;
      src_reg        <= SRC_ZERO;
      cnt_sample_reg <= '0;
      leds_reg       <= '0;
      cycle_cnt_reg  <= '0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      if (accept) begin
        addr_reg     <= addr;
        wdata_reg    <= wdata;
        rd_reg       <= mem_read;
        wr_reg       <= mem_write;
        wait_cnt_reg <= WAIT_LOAD;
      end else if ((state_reg == ST_WAIT) && (wait_cnt_reg != 4'd0)) begin
        wait_cnt_reg <= wait_cnt_reg - 4'd1;
      end
      if (go_resp) begin
        err_lat_reg    <= req_err;
        src_reg        <= req_src;
        cnt_sample_reg <= cycle_cnt_reg;
      end
      if (led_we) leds_reg <= req_wdata[7:0];
    end
  end

  always_comb begin
    rdata_mux = '0;
    case (src_reg)
      SRC_RAM: rdata_mux = ram_q;
      SRC_LED: rdata_mux = {24'd0, leds_reg};
      SRC_CNT: rdata_mux = cnt_sample_reg;
      default: rdata_mux = '0;
    endcase
  end

  // Response registers update as RESP ends; rdata holds until the next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_reg <= 1'b0;
      err_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      ready_reg <= (state_reg == ST_RESP);
      err_reg   <= (state_reg == ST_RESP) && err_lat_reg;
      if ((state_reg == ST_RESP) && rd_reg) rdata_reg <= rdata_mux;
    end
  end

  assign ready = ready_reg;
  assign err   = err_reg;
  assign rdata = rdata_reg;
  assign leds  = leds_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a WAIT_CYCLES=2 instance for the main
// sequence and a WAIT_CYCLES=0 instance for the zero-wait latency case.
module tb_mem_responder;
  import mem_responder_pkg::*;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    bit          chk;
    int          id;
  } exp_t;

  localparam int W0 = 2;
  localparam int W1 = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read0 = 0, mem_write0 = 0, mem_read1 = 0, mem_write1 = 0;
  logic [31:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
  logic [31:0] rdata0, rdata1;
  logic        ready0, ready1, err0, err1;
  logic [7:0]  leds0, leds1;

  int   tests = 0;
  int   fails = 0;
  int   txn_id = 0;
  exp_t q0[$], q1[$];
  exp_t e0, e1;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W0), .MMIO_BASE(32'h4000_0000)) dut0 (
    .clk(clk), .reset(reset), .mem_read(mem_read0), .mem_write(mem_write0),
    .addr(addr0), .wdata(wdata0), .rdata(rdata0), .ready(ready0), .err(err0), .leds(leds0)
  );

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W1), .MMIO_BASE(32'h4000_0000)) dut1 (
    .clk(clk), .reset(reset), .mem_read(mem_read1), .mem_write(mem_write1),
    .addr(addr1), .wdata(wdata1), .rdata(rdata1), .ready(ready1), .err(err1), .leds(leds1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] %s ok (%h)", name, act);
    end
  endtask

  // Monitors: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ready0) begin
      tests++;
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL dut0_resp: unexpected ready, err=%0b rdata=%h", err0, rdata0);
      end else begin
        e0 = q0.pop_front();
        if (err0 !== e0.err || (e0.chk && rdata0 !== e0.rdata)) begin
          fails++;
          $display("FAIL dut0_resp#%0d: got err=%0b rdata=%h expected err=%0b rdata=%h",
                   e0.id, err0, rdata0, e0.err, e0.rdata);
        end else begin
          $display("[TB] dut0 resp#%0d err=%0b rdata=%h", e0.id, err0, rdata0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ready1) begin
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL dut1_resp: unexpected ready, err=%0b rdata=%h", err1, rdata1);
      end else begin
        e1 = q1.pop_front();
        if (err1 !== e1.err || (e1.chk && rdata1 !== e1.rdata)) begin
          fails++;
          $display("FAIL dut1_resp#%0d: got err=%0b rdata=%h expected err=%0b rdata=%h",
                   e1.id, err1, rdata1, e1.err, e1.rdata);
        end else begin
          $display("[TB] dut1 resp#%0d err=%0b rdata=%h", e1.id, err1, rdata1);
        end
      end
    end
  end

  task automatic drive(input int inst, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (inst == 0) begin
      mem_read0 = rd; mem_write0 = wr; addr0 = a; wdata0 = d;
    end else begin
      mem_read1 = rd; mem_write1 = wr; addr1 = a; wdata1 = d;
    end
  endtask

  // Entered just after a negedge; returns just after a negedge with the DUT idle.
  task automatic req(input int inst, input bit rd, input bit wr,
                     input logic [31:0] a, input logic [31:0] d,
                     input bit e_err, input logic [31:0] e_data, input bit e_chk,
                     output logic [31:0] got);
    exp_t e;
    int   k;
    logic rdy;
    e.err = e_err; e.rdata = e_data; e.chk = e_chk; e.id = txn_id++;
    if (inst == 0) q0.push_back(e);
    else           q1.push_back(e);
    drive(inst, rd, wr, a, d);
    @(posedge clk);
    k = 0;
    do begin
      @(posedge clk);
      k++;
      @(negedge clk);
      rdy = (inst == 0) ? ready0 : ready1;
    end while (!rdy && k < 50);
    got = (inst == 0) ? rdata0 : rdata1;
    chk($sformatf("latency#%0d", e.id), 32'(k), (inst == 0) ? 32'(W0 + 1) : 32'(W1 + 1));
    drive(inst, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] got, c1, c2;
  int          pulses;

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, ready0}, 32'd0);
    chk("rst_err",   {31'd0, err0},   32'd0);
    chk("rst_rdata", rdata0,          32'd0);
    chk("rst_leds",  {24'd0, leds0},  32'd0);

    req(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 0, 32'h0, 0, got);
    req(0, 1, 0, 32'h10, 32'h0, 0, 32'hDEAD_BEEF, 1, got);
    req(0, 0, 1, 32'h12, 32'h1234, 1, 32'h0, 0, got);
    req(0, 1, 0, 32'h10, 32'h0, 0, 32'hDEAD_BEEF, 1, got);
    req(0, 0, 1, 32'h20, 32'h55, 0, 32'h0, 0, got);
    req(0, 1, 1, 32'h20, 32'h99, 1, 32'h0, 1, got);
    req(0, 1, 0, 32'h20, 32'h0, 0, 32'h55, 1, got);
    req(0, 1, 0, 32'h400, 32'h0, 1, 32'h0, 1, got);

    req(0, 0, 1, 32'h4000_0000, 32'hFFFF_FFA5, 0, 32'h0, 0, got);
    chk("leds_a5", {24'd0, leds0}, 32'hA5);
    req(0, 1, 0, 32'h4000_0000, 32'h0, 0, 32'hA5, 1, got);
    req(0, 1, 0, 32'h4000_0008, 32'h0, 1, 32'h0, 1, got);
    req(0, 0, 1, 32'h4000_0004, 32'h1234_5678, 0, 32'h0, 0, got);

    req(0, 1, 0, 32'h4000_0004, 32'h0, 0, 32'h0, 0, c1);
    repeat (5) @(negedge clk);
    req(0, 1, 0, 32'h4000_0004, 32'h0, 0, 32'h0, 0, c2);
    chk("cnt_delta", c2 - c1, 32'd10);

    // One read held for 8 cycles must yield exactly one response.
    q0.push_back('{err: 1'b0, rdata: 32'hDEAD_BEEF, chk: 1'b1, id: txn_id++});
    drive(0, 1, 0, 32'h10, 32'h0);
    pulses = 0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (ready0) pulses++;
    end
    chk("hold_pulses", 32'(pulses), 32'd1);
    chk("hold_state_release", {30'd0, dut0.state_reg}, {30'd0, ST_RELEASE});
    drive(0, 0, 0, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("hold_state_idle", {30'd0, dut0.state_reg}, {30'd0, ST_IDLE});

    // Reset in the middle of a write's wait phase drops the write.
    req(0, 0, 1, 32'h30, 32'h1111_1111, 0, 32'h0, 0, got);
    req(0, 1, 0, 32'h10, 32'h0, 0, 32'hDEAD_BEEF, 1, got);
    drive(0, 0, 1, 32'h30, 32'h2222_2222);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 32'h0, 32'h0);
    #1;
    chk("midrst_ready", {31'd0, ready0}, 32'd0);
    chk("midrst_err",   {31'd0, err0},   32'd0);
    chk("midrst_rdata", rdata0,          32'd0);
    chk("midrst_leds",  {24'd0, leds0},  32'd0);
    chk("midrst_state", {30'd0, dut0.state_reg}, {30'd0, ST_IDLE});
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    req(0, 1, 0, 32'h30, 32'h0, 0, 32'h1111_1111, 1, got);

    req(1, 0, 1, 32'h30, 32'hCAFE_F00D, 0, 32'h0, 0, got);
    req(1, 1, 0, 32'h30, 32'h0, 0, 32'hCAFE_F00D, 1, got);
    req(1, 1, 0, 32'h31, 32'h0, 1, 32'h0, 1, got);

    repeat (3) @(negedge clk);
    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL missing_resp: outstanding %0d/%0d expected 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multi-cycle CPU's memory strobes (MemRead/MemWrite plus IorD-selected address). It serves word reads and writes from a local word RAM or a small MMIO window, inserts a configurable number of wait states, and signals completion with a one-cycle `ready` pulse. It sits between the datapath's address/write-data registers and the memory-data register (MDR).

## Interface
- `DEPTH_WORDS`, 256: RAM size in 32-bit words. Must be a power of two.
- `WAIT_CYCLES`, 2: wait states inserted before the response. Range 0..15.
- `MMIO_BASE`, 32'h4000_0000: base address of the MMIO window.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `mem_read` in 1: read strobe from the controller.
- `mem_write` in 1: write strobe from the controller.
- `addr` in 32: byte address.
- `wdata` in 32: write data.
- `rdata` out 32: read data. Valid while `ready`=1, held until the next accepted read.
- `ready` out 1: one-cycle completion pulse.
- `err` out 1: qualifies `ready`. High means the access was rejected.
- `leds` out 8: MMIO LED register.

## Operation
- FSM states are IDLE, WAIT, RESP and RELEASE.
- **IDLE:** if `mem_read` or `mem_write` is high at a clk edge, the request is accepted.
  - Latch `addr`, `wdata` and the strobe type.
  - Go to WAIT, or straight to RESP if `WAIT_CYCLES`=0.
- **WAIT:** a 4-bit counter loads `WAIT_CYCLES`-1 on accept and decrements each cycle. When the counter reaches 0, go to RESP.
  - The RAM write, or the read fetch into the `rdata` register, happens on this exit edge.
- **RESP:** `ready`=1 for exactly one cycle, with `err` valid in the same cycle. Then go to RELEASE.
- **RELEASE:** stay until `mem_read`=`mem_write`=0, then go to IDLE. A strobe held high from the controller state is never served twice.
- **Error cases:** each sets `err`=1, forces `rdata`=0 on reads, blocks any write, and keeps the full latency.
  - Both strobes high at accept.
  - `addr[1:0]` not equal to 0.
  - RAM address at or above `DEPTH_WORDS`*4, outside the MMIO window.
  - MMIO offset not 0x0 or 0x4.
- **MMIO:**
  - Offset 0x0 is the LED register: R/W, `leds` = `wdata[7:0]`. Reads return zero-extended `leds`.
  - Offset 0x4 is the cycle counter: 32-bit, read-only, increments every clk since reset and wraps to 0 after 0xFFFF_FFFF. Writes are ignored with `err`=0.
- **RAM:** word index is `addr[log2(DEPTH_WORDS)+1:2]`. No byte enables. Contents are not cleared by reset.

## Timing
- **Reset values:** state IDLE, `ready`=0, `err`=0, `rdata`=0, `leds`=0, cycle counter 0, wait counter 0.
- **Latency:** `ready` is high exactly `WAIT_CYCLES`+1 cycles after the accept edge.
  - `WAIT_CYCLES`=2: accept at edge N, `ready` high in the cycle after edge N+3.
- **Write visibility:** a write commits on the edge into RESP. A read accepted in the next IDLE returns the new value.
- **Minimum spacing:** back-to-back requests are at least `WAIT_CYCLES`+3 cycles apart, because RELEASE needs one cycle with strobes low.
- **Held inputs:** `addr` and `wdata` changes after the accept edge are ignored.
- **Cycle counter sampling:** a counter read returns the value sampled on the exit edge into RESP.
- **Mid-operation reset:**
  - Abort in any state and return to IDLE.
  - A pending write is dropped.
  - A write already committed on the exit edge stays in RAM.

## Structure
- **Package `mem_responder_pkg`:**
  - FSM state enum (2 bits).
  - MMIO offsets `MMIO_LED_OFF`=0x0 and `MMIO_CNT_OFF`=0x4.
  - MMIO window size of 16 bytes.
- **Sub-module `word_ram`:** single-port synchronous RAM (`DEPTH_WORDS` x 32, one write enable, registered read). Instantiated once.
- **Top level:** holds the FSM, request latches, decode/error logic, LED register and cycle counter.

## Test plan
- **Write/read with `WAIT_CYCLES`=2:** write 0xDEADBEEF to 0x10, then read 0x10.
  - Each `ready` comes 3 cycles after accept.
  - `rdata`=0xDEADBEEF, `err`=0.
- **Misaligned write:** write 0x1234 to 0x12 -> `err`=1, `ready` pulse. A following read of 0x10 still returns 0xDEADBEEF.
- **Both strobes high:** read and write of 0x20 together -> `err`=1, RAM at 0x20 unchanged. Out-of-range read 0x400 with `DEPTH_WORDS`=256 -> `err`=1, `rdata`=0.
- **MMIO:**
  - Write 0xA5 to 0x4000_0000 -> `leds`=0xA5, and a read returns 0x0000_00A5.
  - Two counter reads 10 cycles apart differ by exactly 10.
- **Strobe held high:** `mem_read` held for 8 cycles -> exactly one `ready` pulse. FSM stays in RELEASE until the strobe drops.
- **Reset during WAIT of a write to 0x30:**
  - Outputs return to reset values within the same cycle.
  - A later read of 0x30 returns the old value.
  - `WAIT_CYCLES`=0 variant: `ready` comes 1 cycle after accept.
